mem_stage_lsu: RTL and testbench

- Memory stage of the dual-issue pipeline, directly downstream of the execute stage.
- Registers both lanes' execute results and issues loads/stores for the first lane over a req/addr_ok/data_ok data-SRAM bus.
- Aligns and extends load data, detects misaligned addresses, and stalls the pipeline while a bus transaction is outstanding.
- The second lane never accesses memory; its result passes through.

---
 rtl/mem_stage_lsu.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- memory stage of the dual-issue pipeline.
//
// Holds the issue group handed over by the execute stage. It performs the
// first lane's load or store over a req/addr_ok/data_ok data-SRAM bus. It
// aligns and extends returned load data and flags misaligned addresses as
// AdEL/AdES. While a bus transaction is outstanding it holds the pipeline.
// The second lane never touches memory and only passes through.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   flush              kill the instruction held in this stage
//   in_*               issue group from EX (captured while mem_stall=0)
//   mem_stall          stage busy, upstream must hold its outputs
//   wb_*               results toward write-back, qualified by wb_valid
//   data_*             data-SRAM bus (one outstanding transaction at most)

module mem_stage_lsu #(
  parameter int EXP_ADEL_BIT = 4,
  parameter int EXP_ADES_BIT = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [3:0]  in_mem_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_out_second,
  input  logic [13:0] in_exp_first,
  input  logic [13:0] in_exp_second,
  input  logic [31:0] in_pc_first,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_first_data,
  output logic [31:0] wb_second_data,
  output logic [13:0] wb_exp_first,
  output logic [13:0] wb_exp_second,
  output logic [31:0] wb_pc_first,
  output logic [31:0] wb_badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [3:0]  mem_op_q, mem_op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] out_second_q, out_second_d;
  logic [13:0] exp_first_q, exp_first_d;
  logic [13:0] exp_second_q, exp_second_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        capture;
  logic        adel;
  logic        ades;
  logic [13:0] exp_new;
  logic        start_mem;

  // Loads return a byte/half/word picked out of the 32-bit bus word by the
  // low address bits (little-endian), then sign- or zero-extended.
  function automatic logic [31:0] align_load(input logic [3:0]  op,
                                             input logic [1:0]  a,
                                             input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {a, 3'b000};
    case (op)
      OP_LB:   align_load = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  align_load = {24'd0, shifted[7:0]};
      OP_LH:   align_load = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  align_load = {16'd0, shifted[15:0]};
      default: align_load = rdata;
    endcase
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
      default:              op_size = 2'd2;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
              (op == OP_LHU) || (op == OP_LW);
  endfunction

  // A new issue group can only enter while nothing is outstanding on the
  // bus. Address errors are folded into the exception vector as it is
  // captured. That way, a faulting access never reaches the bus.
  always_comb begin
    capture = (state_q == IDLE) || (state_q == DONE);
    adel = ((in_mem_op == OP_LH || in_mem_op == OP_LHU) && in_addr[0]) ||
           ((in_mem_op == OP_LW) && (in_addr[1:0] != 2'b00));
    ades = ((in_mem_op == OP_SH) && in_addr[0]) ||
           ((in_mem_op == OP_SW) && (in_addr[1:0] != 2'b00));
    exp_new = in_exp_first;
    exp_new[EXP_ADEL_BIT] = in_exp_first[EXP_ADEL_BIT] | adel;
    exp_new[EXP_ADES_BIT] = in_exp_first[EXP_ADES_BIT] | ades;
    start_mem = capture && in_valid && !flush &&
                (in_mem_op != OP_NONE) && (exp_new == 14'd0);
  end

  // State register and stage register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      mem_op_q     <= 4'd0;
      addr_q       <= 32'd0;
      store_data_q <= 32'd0;
      out_second_q <= 32'd0;
      exp_first_q  <= 14'd0;
      exp_second_q <= 14'd0;
      pc_q         <= 32'd0;
      badvaddr_q   <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_op_q     <= mem_op_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      out_second_q <= out_second_d;
      exp_first_q  <= exp_first_d;
      exp_second_q <= exp_second_d;
      pc_q         <= pc_d;
      badvaddr_q   <= badvaddr_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic. A flush landing in the same cycle as the bus handshake
  // is resolved by what the bus has already seen. If the request was
  // accepted, its data_ok must still be drained. If the data has already
  // arrived, there is nothing left to drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start_mem ? REQ : IDLE;
      REQ: begin
        if (data_addr_ok)
          state_d = flush ? DRAIN : WAIT;
        else if (flush)
          state_d = IDLE;
      end
      WAIT: begin
        if (data_data_ok)
          state_d = flush ? IDLE : DONE;
        else if (flush)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (data_data_ok)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage register update: full capture when not stalled. Otherwise the
  // held instruction stays put. It is only invalidated by a flush, or it
  // picks up its aligned load data.
  always_comb begin
    valid_d      = valid_q;
    mem_op_d     = mem_op_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    out_second_d = out_second_q;
    exp_first_d  = exp_first_q;
    exp_second_d = exp_second_q;
    pc_d         = pc_q;
    badvaddr_d   = badvaddr_q;
    rdata_d      = rdata_q;
    if (capture) begin
      valid_d      = in_valid && !flush;
      mem_op_d     = in_mem_op;
      addr_d       = in_addr;
      store_data_d = in_store_data;
      out_second_d = in_out_second;
      exp_first_d  = exp_new;
      exp_second_d = in_exp_second;
      pc_d         = in_pc_first;
      badvaddr_d   = (adel || ades) ? in_addr : 32'd0;
      rdata_d      = 32'd0;
    end else begin
      if (flush)
        valid_d = 1'b0;
      if (state_q == WAIT && data_data_ok)
        rdata_d = align_load(mem_op_q, addr_q[1:0], data_rdata);
    end
  end

  // Outputs. Bus fields are zero unless a request is actually presented.
  // Store data is replicated across byte lanes, so the memory can pick
  // whichever lanes the address selects.
  always_comb begin
    mem_stall  = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);
    data_req   = (state_q == REQ);
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    if (data_req) begin
      data_wr   = !is_load(mem_op_q);
      data_size = op_size(mem_op_q);
      data_addr = addr_q;
      case (mem_op_q)
        OP_SB:   data_wdata = {4{store_data_q[7:0]}};
        OP_SH:   data_wdata = {2{store_data_q[15:0]}};
        default: data_wdata = store_data_q;
      endcase
    end
    wb_valid = valid_q && !flush &&
               ((state_q == DONE) ||
                ((state_q == IDLE) &&
                 ((mem_op_q == OP_NONE) || (exp_first_q != 14'd0))));
    wb_first_data  = is_load(mem_op_q) ? rdata_q : addr_q;
    wb_second_data = out_second_q;
    wb_exp_first   = exp_first_q;
    wb_exp_second  = exp_second_q;
    wb_pc_first    = pc_q;
    wb_badvaddr    = badvaddr_q;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu -- directed bench for mem_stage_lsu.
// The bench drives a linear sequence of issue groups and bus responses. It
// compares the stage outputs against hand-computed values.

module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic [3:0]  in_mem_op;
  logic [31:0] in_addr;
  logic [31:0] in_store_data;
  logic [31:0] in_out_second;
  logic [13:0] in_exp_first;
  logic [13:0] in_exp_second;
  logic [31:0] in_pc_first;
  logic        mem_stall;
  logic        wb_valid;
  logic [31:0] wb_first_data;
  logic [31:0] wb_second_data;
  logic [13:0] wb_exp_first;
  logic [13:0] wb_exp_second;
  logic [31:0] wb_pc_first;
  logic [31:0] wb_badvaddr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.EXP_ADEL_BIT(4), .EXP_ADES_BIT(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_mem_op(in_mem_op), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_out_second(in_out_second),
    .in_exp_first(in_exp_first), .in_exp_second(in_exp_second),
    .in_pc_first(in_pc_first),
    .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_first_data(wb_first_data), .wb_second_data(wb_second_data),
    .wb_exp_first(wb_exp_first), .wb_exp_second(wb_exp_second),
    .wb_pc_first(wb_pc_first), .wb_badvaddr(wb_badvaddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic fl);
    in_valid      = v;
    in_mem_op     = op;
    in_addr       = a;
    in_store_data = sd;
    flush         = fl;
    #1;
  endtask

  task automatic driveBus(input logic aok, input logic dok, input logic [31:0] rd);
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata   = rd;
  endtask

  // Capture a load, accept it at once and return rdata one cycle later.
  // Ends in the DONE cycle.
  task automatic doLoad(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rd);
    applyStimulus(1'b1, op, a, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    driveBus(1'b1, 1'b0, 32'd0);
    tick();
    driveBus(1'b0, 1'b1, rd);
    tick();
    driveBus(1'b0, 1'b0, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    checkOutput({tag, "_mem_stall"}, {31'd0, mem_stall}, 32'd0);
    checkOutput({tag, "_data_req"}, {31'd0, data_req}, 32'd0);
    checkOutput({tag, "_data_wr"}, {31'd0, data_wr}, 32'd0);
    checkOutput({tag, "_data_size"}, {30'd0, data_size}, 32'd0);
    checkOutput({tag, "_data_addr"}, data_addr, 32'd0);
    checkOutput({tag, "_data_wdata"}, data_wdata, 32'd0);
    checkOutput({tag, "_wb_first"}, wb_first_data, 32'd0);
    checkOutput({tag, "_wb_second"}, wb_second_data, 32'd0);
    checkOutput({tag, "_wb_exp_first"}, {18'd0, wb_exp_first}, 32'd0);
    checkOutput({tag, "_wb_exp_second"}, {18'd0, wb_exp_second}, 32'd0);
    checkOutput({tag, "_wb_pc"}, wb_pc_first, 32'd0);
    checkOutput({tag, "_wb_badvaddr"}, wb_badvaddr, 32'd0);
  endtask

  initial begin
    resetn        = 1'b0;
    in_out_second = 32'd0;
    in_exp_first  = 14'd0;
    in_exp_second = 14'd0;
    in_pc_first   = 32'd0;
    driveBus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkResetOutputs("reset");
    resetn = 1'b1;
    tick();

    // Non-memory instruction passes straight through in one cycle
    in_out_second = 32'h0000_0077;
    in_pc_first   = 32'h0000_0400;
    in_exp_second = 14'h0003;
    applyStimulus(1'b1, 4'd0, 32'h0000_0055, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("alu_first", wb_first_data, 32'h0000_0055);
    checkOutput("alu_second", wb_second_data, 32'h0000_0077);
    checkOutput("alu_pc", wb_pc_first, 32'h0000_0400);
    checkOutput("alu_exp_second", {18'd0, wb_exp_second}, 32'h0000_0003);
    in_exp_second = 14'd0;

    // Flush at capture leaves the stage empty
    applyStimulus(1'b1, 4'd0, 32'h0000_0066, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("flushcap_wb_valid", {31'd0, wb_valid}, 32'd0);

    // LW 0x1000: addr_ok on the 2nd REQ cycle, data_ok on the 3rd WAIT cycle
    applyStimulus(1'b1, 4'd5, 32'h0000_1000, 32'd0, 1'b0);
    checkOutput("lw_idle_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("lw_req1", {31'd0, data_req}, 32'd1);
    checkOutput("lw_wr", {31'd0, data_wr}, 32'd0);
    checkOutput("lw_size", {30'd0, data_size}, 32'd2);
    checkOutput("lw_addr", data_addr, 32'h0000_1000);
    checkOutput("lw_stall_req", {31'd0, mem_stall}, 32'd1);
    tick();
    checkOutput("lw_req2", {31'd0, data_req}, 32'd1);
    driveBus(1'b1, 1'b0, 32'd0);
    tick();
    driveBus(1'b0, 1'b0, 32'd0);
    checkOutput("lw_wait1_req", {31'd0, data_req}, 32'd0);
    checkOutput("lw_wait1_stall", {31'd0, mem_stall}, 32'd1);
    checkOutput("lw_wait1_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    checkOutput("lw_wait2_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    checkOutput("lw_wait3_stall", {31'd0, mem_stall}, 32'd1);
    driveBus(1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    driveBus(1'b0, 1'b0, 32'd0);
    checkOutput("lw_done_wbv", {31'd0, wb_valid}, 32'd1);
    checkOutput("lw_done_data", wb_first_data, 32'hDEAD_BEEF);
    checkOutput("lw_done_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    checkOutput("lw_after_wbv", {31'd0, wb_valid}, 32'd0);

    // Load alignment and extension
    doLoad(4'd1, 32'h0000_1003, 32'h8012_3456);
    checkOutput("lb_wbv", {31'd0, wb_valid}, 32'd1);
    checkOutput("lb_data", wb_first_data, 32'hFFFF_FF80);
    tick();
    doLoad(4'd2, 32'h0000_1003, 32'h8012_3456);
    checkOutput("lbu_data", wb_first_data, 32'h0000_0080);
    tick();
    doLoad(4'd4, 32'h0000_1002, 32'h8001_0000);
    checkOutput("lhu_data", wb_first_data, 32'h0000_8001);
    tick();
    doLoad(4'd3, 32'h0000_1002, 32'h8001_0000);
    checkOutput("lh_data", wb_first_data, 32'hFFFF_8001);
    tick();

    // Misaligned SH raises AdES without touching the bus
    applyStimulus(1'b1, 4'd7, 32'h0000_1001, 32'h0000_BEEF, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("sh_mis_req", {31'd0, data_req}, 32'd0);
    checkOutput("sh_mis_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("sh_mis_wbv", {31'd0, wb_valid}, 32'd1);
    checkOutput("sh_mis_exp", {18'd0, wb_exp_first}, 32'h0000_0020);
    checkOutput("sh_mis_badv", wb_badvaddr, 32'h0000_1001);
    tick();
    checkOutput("sh_mis_after_wbv", {31'd0, wb_valid}, 32'd0);
    checkOutput("sh_mis_after_stall", {31'd0, mem_stall}, 32'd0);

    // Misaligned LW raises AdEL
    applyStimulus(1'b1, 4'd5, 32'h0000_1002, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("lw_mis_req", {31'd0, data_req}, 32'd0);
    checkOutput("lw_mis_exp", {18'd0, wb_exp_first}, 32'h0000_0010);
    checkOutput("lw_mis_badv", wb_badvaddr, 32'h0000_1002);

    // Incoming exception suppresses the access
    in_exp_first = 14'h0001;
    applyStimulus(1'b1, 4'd5, 32'h0000_1000, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    in_exp_first = 14'd0;
    checkOutput("exc_req", {31'd0, data_req}, 32'd0);
    checkOutput("exc_wbv", {31'd0, wb_valid}, 32'd1);
    checkOutput("exc_exp", {18'd0, wb_exp_first}, 32'h0000_0001);
    tick();

    // SB with byte-replicated data
    applyStimulus(1'b1, 4'd6, 32'h0000_1002, 32'h1234_56AB, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("sb_req", {31'd0, data_req}, 32'd1);
    checkOutput("sb_wr", {31'd0, data_wr}, 32'd1);
    checkOutput("sb_size", {30'd0, data_size}, 32'd0);
    checkOutput("sb_wdata", data_wdata, 32'hABAB_ABAB);
    checkOutput("sb_addr", data_addr, 32'h0000_1002);
    driveBus(1'b1, 1'b0, 32'd0);
    tick();
    driveBus(1'b0, 1'b1, 32'd0);
    tick();
    driveBus(1'b0, 1'b0, 32'd0);
    checkOutput("sb_done_wbv", {31'd0, wb_valid}, 32'd1);
    checkOutput("sb_done_data", wb_first_data, 32'h0000_1002);
    tick();

    // Flush in REQ before addr_ok withdraws the request
    applyStimulus(1'b1, 4'd5, 32'h0000_1008, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("reqflush_req", {31'd0, data_req}, 32'd1);
    checkOutput("reqflush_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("reqflush_after_req", {31'd0, data_req}, 32'd0);
    checkOutput("reqflush_after_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("reqflush_after_wbv", {31'd0, wb_valid}, 32'd0);

    // Flush in WAIT, data_ok four cycles later, next load held off meanwhile
    applyStimulus(1'b1, 4'd5, 32'h0000_2000, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    driveBus(1'b1, 1'b0, 32'd0);
    tick();
    driveBus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("wflush_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    in_out_second = 32'h0000_AAAA;
    applyStimulus(1'b1, 4'd5, 32'h0000_3000, 32'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("drain%0d_stall", i), {31'd0, mem_stall}, 32'd1);
      checkOutput($sformatf("drain%0d_req", i), {31'd0, data_req}, 32'd0);
      checkOutput($sformatf("drain%0d_wbv", i), {31'd0, wb_valid}, 32'd0);
      tick();
    end
    checkOutput("drain4_stall", {31'd0, mem_stall}, 32'd1);
    driveBus(1'b0, 1'b1, 32'h5555_5555);
    tick();
    driveBus(1'b0, 1'b0, 32'd0);
    checkOutput("postdrain_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("postdrain_req", {31'd0, data_req}, 32'd0);
    checkOutput("postdrain_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("next_req", {31'd0, data_req}, 32'd1);
    checkOutput("next_addr", data_addr, 32'h0000_3000);

    // Reset while in REQ abandons the request
    resetn = 1'b0;
    tick();
    checkResetOutputs("rst_req");
    resetn = 1'b1;
    in_out_second = 32'd0;
    in_pc_first   = 32'd0;
    tick();
    driveBus(1'b0, 1'b1, 32'h1111_1111);
    tick();
    driveBus(1'b0, 1'b0, 32'd0);
    checkOutput("rst_stray_ok_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("rst_stray_ok_wbv", {31'd0, wb_valid}, 32'd0);
    doLoad(4'd5, 32'h0000_1004, 32'h1122_3344);
    checkOutput("rst_reload_wbv", {31'd0, wb_valid}, 32'd1);
    checkOutput("rst_reload_data", wb_first_data, 32'h1122_3344);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
